uncache_wbuf: RTL and testbench

Uncached-access agent between the LSU and the uncache port group of the CPU AXI interface. Posts uncached stores into a small FIFO so the pipeline does not wait for the AXI B response. Drains stores one at a time through the `uncache_wr_*` handshake. Holds each uncached load until every older store has received its B response, which preserves MMIO ordering.

---
 rtl/uncache_wbuf_pkg.sv | 27 ++
 rtl/uncache_wbuf_if.sv | 57 +++++
 rtl/uncache_wbuf_sync_fifo.sv | 63 ++++++
 rtl/uncache_wbuf.sv | 142 ++++++++++++++
 tb/tb_uncache_wbuf.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/uncache_wbuf_pkg.sv
// Shared types for the uncached-access agent: store-buffer entry and FSM encodings.
package uncache_wbuf_pkg;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        virt_t       addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        uint32_t     data;
    } uncache_wr_entry_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } uwbuf_wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DRAIN = 2'd1,
        R_REQ   = 2'd2,
        R_RESP  = 2'd3
    } uwbuf_rstate_t;

endpackage

// File: rtl/uncache_wbuf_if.sv
// LSU-side and downstream (AXI uncache port group) bundles for the uncached agent.
interface uncache_cpu_if;
    import uncache_wbuf_pkg::*;

    logic    wr_valid;
    virt_t   wr_addr;
    logic [2:0] wr_size;
    logic [3:0] wr_wstrb;
    uint32_t wr_data;
    logic    wr_ready;
    logic    rd_valid;
    virt_t   rd_addr;
    logic [2:0] rd_size;
    logic    rd_ready;
    logic    rd_data_valid;
    uint32_t rd_data;

    // LSU drives requests
    modport master (
        output wr_valid, wr_addr, wr_size, wr_wstrb, wr_data, rd_valid, rd_addr, rd_size,
        input  wr_ready, rd_ready, rd_data_valid, rd_data
    );
    // write buffer receives requests
    modport slave (
        input  wr_valid, wr_addr, wr_size, wr_wstrb, wr_data, rd_valid, rd_addr, rd_size,
        output wr_ready, rd_ready, rd_data_valid, rd_data
    );
endinterface

interface uncache_axi_if;
    import uncache_wbuf_pkg::*;

    logic    wr_req;
    logic [2:0] wr_size;
    logic [3:0] wr_wstrb;
    virt_t   wr_addr;
    uint32_t wr_data;
    logic    wr_rdy;
    logic    wr_bvalid;
    logic    rd_req;
    logic [2:0] rd_size;
    virt_t   rd_addr;
    logic    rd_rdy;
    logic    ret_valid;
    uint32_t ret_data;

    // write buffer issues requests downstream
    modport master (
        output wr_req, wr_size, wr_wstrb, wr_addr, wr_data, rd_req, rd_size, rd_addr,
        input  wr_rdy, wr_bvalid, rd_rdy, ret_valid, ret_data
    );
    // AXI bridge answers them
    modport slave (
        input  wr_req, wr_size, wr_wstrb, wr_addr, wr_data, rd_req, rd_size, rd_addr,
        output wr_rdy, wr_bvalid, rd_rdy, ret_valid, ret_data
    );
endinterface

// File: rtl/uncache_wbuf_sync_fifo.sv
// Small synchronous FIFO; entry storage is not reset, only pointers and count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // entry storage written at the tail; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    // pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= {PTR_W{1'b0}};
            r_tail <= {PTR_W{1'b0}};
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_W'(1);
            if (w_do_pop)  r_head <= r_head + PTR_W'(1);
        end
    end

    // occupancy tracks push/pop, simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uncache_wbuf.sv
// Uncached store buffer plus ordered load path between the LSU and the uncache AXI ports.
module uncache_wbuf
    import uncache_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    uncache_cpu_if.slave cpu,
    uncache_axi_if.master axi,
    output logic         o_wbuf_empty
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    uwbuf_wstate_t      r_wstate, w_wstate_nxt;
    uwbuf_rstate_t      r_rstate, w_rstate_nxt;
    virt_t              r_rd_addr;
    logic [2:0]         r_rd_size;
    uncache_wr_entry_t  w_head;
    uncache_wr_entry_t  w_push_entry;
    logic [CNT_W-1:0]   w_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_wr_ready;
    logic               w_rd_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_accept;

    // stores are refused while a load waits so younger stores stay behind it
    assign w_wr_ready   = reset || (!w_fifo_full && (r_rstate == R_IDLE));
    assign w_rd_ready   = reset || ((r_rstate == R_IDLE) && !cpu.wr_valid);
    assign w_push       = cpu.wr_valid && w_wr_ready;
    assign w_pop        = (r_wstate == W_RESP) && axi.wr_bvalid;
    assign w_rd_accept  = cpu.rd_valid && w_rd_ready;
    assign w_push_entry = '{addr: cpu.wr_addr, size: cpu.wr_size, wstrb: cpu.wr_wstrb, data: cpu.wr_data};

    sync_fifo #(
        .WIDTH ($bits(uncache_wr_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // drain and load state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // load address/size captured on accept and held until the load completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr <= 32'd0;
            r_rd_size <= 3'd0;
        end else if (w_rd_accept) begin
            r_rd_addr <= cpu.rd_addr;
            r_rd_size <= cpu.rd_size;
        end else begin
            r_rd_addr <= r_rd_addr;
            r_rd_size <= r_rd_size;
        end
    end

    // drain FSM: one store outstanding downstream, next request right after bvalid if work remains
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (!w_fifo_empty) w_wstate_nxt = W_REQ;
                else               w_wstate_nxt = W_IDLE;
            end
            W_REQ: begin
                if (axi.wr_rdy) w_wstate_nxt = W_RESP;
                else            w_wstate_nxt = W_REQ;
            end
            W_RESP: begin
                if (axi.wr_bvalid) begin
                    if ((w_count > CNT_W'(1)) || w_push) w_wstate_nxt = W_REQ;
                    else                                  w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // load FSM: a load waits until every older store has its B response
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_rd_accept) w_rstate_nxt = R_DRAIN;
                else             w_rstate_nxt = R_IDLE;
            end
            R_DRAIN: begin
                if (w_fifo_empty && (r_wstate == W_IDLE)) w_rstate_nxt = R_REQ;
                else                                      w_rstate_nxt = R_DRAIN;
            end
            R_REQ: begin
                if (axi.rd_rdy) w_rstate_nxt = R_RESP;
                else            w_rstate_nxt = R_REQ;
            end
            R_RESP: begin
                if (axi.ret_valid) w_rstate_nxt = R_IDLE;
                else               w_rstate_nxt = R_RESP;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // outputs: requests decode registered state only; load data passes straight through
    always_comb begin
        cpu.wr_ready      = w_wr_ready;
        cpu.rd_ready      = w_rd_ready;
        cpu.rd_data_valid = !reset && (r_rstate == R_RESP) && axi.ret_valid;
        cpu.rd_data       = axi.ret_data;
        axi.wr_req        = !reset && (r_wstate == W_REQ);
        axi.wr_addr       = w_head.addr;
        axi.wr_size       = w_head.size;
        axi.wr_wstrb      = w_head.wstrb;
        axi.wr_data       = w_head.data;
        axi.rd_req        = !reset && (r_rstate == R_REQ);
        axi.rd_addr       = r_rd_addr;
        axi.rd_size       = r_rd_size;
        o_wbuf_empty      = reset || (w_fifo_empty && (r_wstate == W_IDLE));
    end
endmodule

// File: tb/tb_uncache_wbuf.sv
// Randomized bench for uncache_wbuf against a transaction-level ordering model.
module tb_uncache_wbuf;
    import uncache_wbuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int NCYC  = 5000;

    logic clk;
    logic reset;
    logic wbuf_empty;

    uncache_cpu_if cpu_if ();
    uncache_axi_if axi_if ();

    uncache_wbuf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (cpu_if),
        .axi          (axi_if),
        .o_wbuf_empty (wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, expv);
        end
    endtask

    // reference model: stores outstanding in order, one in flight, one pending load
    uncache_wr_entry_t exp_q[$];
    int    occ = 0;
    bit    inflight = 0;
    int    b_delay = 0;
    bit    ld_pending = 0;
    bit    ld_issued = 0;
    virt_t ld_addr = 32'd0;
    logic [2:0] ld_size = 3'd0;
    int    ret_delay = 0;
    bit    prev_occ_nz = 0;
    bit    prev_drain_ok = 0;
    int    n_stores_done = 0;
    int    n_loads_done = 0;

    initial begin
        int p_wr, p_rd, bmax, rmax, want_since;
        bit want_reset;
        bit e_wr_ready, e_rd_ready, e_empty, e_wr_req, e_rd_req, e_dv;
        bit push, wr_hs, b, rd_acc, rd_hs, ret;
        uncache_wr_entry_t ent;

        want_reset = 1'b0;
        want_since = 0;
        reset = 1'b1;
        cpu_if.wr_valid = 1'b0; cpu_if.wr_addr = 32'd0; cpu_if.wr_size = 3'd0;
        cpu_if.wr_wstrb = 4'd0; cpu_if.wr_data = 32'd0;
        cpu_if.rd_valid = 1'b0; cpu_if.rd_addr = 32'd0; cpu_if.rd_size = 3'd0;
        axi_if.wr_rdy = 1'b0; axi_if.wr_bvalid = 1'b0; axi_if.rd_rdy = 1'b0;
        axi_if.ret_valid = 1'b0; axi_if.ret_data = 32'd0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            if (c < 2000)      begin p_wr = 55; p_rd = 8;  bmax = 6; rmax = 3; end
            else if (c < 4000) begin p_wr = 35; p_rd = 25; bmax = 1; rmax = 1; end
            else               begin p_wr = 50; p_rd = 50; bmax = 3; rmax = 2; end

            if (c == 1500 || c == 3500) begin want_reset = 1'b1; want_since = c; end
            if (c < 3) reset = 1'b1;
            else if (want_reset && ((inflight && occ >= 2) || (c - want_since > 300))) begin
                reset = 1'b1; want_reset = 1'b0;
            end else reset = 1'b0;

            cpu_if.wr_valid = !reset && ($urandom_range(0, 99) < p_wr);
            cpu_if.wr_addr  = 32'hBFAF_F000 + ($urandom_range(0, 255) << 2);
            cpu_if.wr_size  = 3'($urandom_range(0, 2));
            cpu_if.wr_wstrb = 4'($urandom);
            cpu_if.wr_data  = $urandom;
            cpu_if.rd_valid = !reset && ($urandom_range(0, 99) < p_rd);
            cpu_if.rd_addr  = {16'hBFD0, 16'($urandom) & 16'hFFFC};
            cpu_if.rd_size  = 3'($urandom_range(0, 2));
            axi_if.wr_rdy   = ($urandom_range(0, 99) < 70);
            axi_if.wr_bvalid = reset ? 1'b0 : (inflight ? (b_delay == 0) : ($urandom_range(0, 99) < 4));
            axi_if.rd_rdy   = ($urandom_range(0, 99) < 60);
            axi_if.ret_valid = reset ? 1'b0 : (ld_issued ? (ret_delay == 0) : ($urandom_range(0, 99) < 4));
            axi_if.ret_data = $urandom;
            #1;

            if (reset) begin
                e_wr_ready = 1'b1; e_rd_ready = 1'b1; e_empty = 1'b1;
                e_wr_req = 1'b0; e_rd_req = 1'b0; e_dv = 1'b0;
            end else begin
                e_wr_ready = (occ < DEPTH) && !ld_pending;
                e_rd_ready = !ld_pending && !cpu_if.wr_valid;
                e_empty    = (occ == 0);
                e_wr_req   = (occ > 0) && !inflight && prev_occ_nz;
                e_rd_req   = ld_pending && !ld_issued && prev_drain_ok;
                e_dv       = ld_issued && axi_if.ret_valid;
            end
            chk("wr_ready", 32'(cpu_if.wr_ready), 32'(e_wr_ready));
            chk("rd_ready", 32'(cpu_if.rd_ready), 32'(e_rd_ready));
            chk("wbuf_empty", 32'(wbuf_empty), 32'(e_empty));
            chk("wr_req", 32'(axi_if.wr_req), 32'(e_wr_req));
            chk("rd_req", 32'(axi_if.rd_req), 32'(e_rd_req));
            chk("rd_data_valid", 32'(cpu_if.rd_data_valid), 32'(e_dv));
            if (e_wr_req) begin
                chk("wr_addr", axi_if.wr_addr, exp_q[0].addr);
                chk("wr_size", 32'(axi_if.wr_size), 32'(exp_q[0].size));
                chk("wr_wstrb", 32'(axi_if.wr_wstrb), 32'(exp_q[0].wstrb));
                chk("wr_data", axi_if.wr_data, exp_q[0].data);
            end
            if (e_rd_req) begin
                chk("rd_addr", axi_if.rd_addr, ld_addr);
                chk("rd_size", 32'(axi_if.rd_size), 32'(ld_size));
            end
            if (e_dv) chk("rd_data", cpu_if.rd_data, axi_if.ret_data);

            if (reset) begin
                exp_q.delete();
                occ = 0; inflight = 0; b_delay = 0;
                ld_pending = 0; ld_issued = 0; ret_delay = 0;
                prev_occ_nz = 0; prev_drain_ok = 0;
            end else begin
                push   = cpu_if.wr_valid && e_wr_ready;
                wr_hs  = e_wr_req && axi_if.wr_rdy;
                b      = inflight && axi_if.wr_bvalid;
                rd_acc = cpu_if.rd_valid && e_rd_ready;
                rd_hs  = e_rd_req && axi_if.rd_rdy;
                ret    = ld_issued && axi_if.ret_valid;
                prev_occ_nz   = (occ != 0);
                prev_drain_ok = ld_pending && !ld_issued && (occ == 0);

                if (inflight && !b && b_delay > 0) b_delay--;
                if (b) begin
                    void'(exp_q.pop_front());
                    occ--; inflight = 0; n_stores_done++;
                end
                if (push) begin
                    ent.addr = cpu_if.wr_addr; ent.size = cpu_if.wr_size;
                    ent.wstrb = cpu_if.wr_wstrb; ent.data = cpu_if.wr_data;
                    exp_q.push_back(ent);
                    occ++;
                end
                if (wr_hs) begin inflight = 1; b_delay = $urandom_range(0, bmax); end

                if (ld_issued && !ret && ret_delay > 0) ret_delay--;
                if (ret) begin ld_pending = 0; ld_issued = 0; n_loads_done++; end
                if (rd_acc) begin
                    ld_pending = 1; ld_addr = cpu_if.rd_addr; ld_size = cpu_if.rd_size;
                end
                if (rd_hs) begin ld_issued = 1; ret_delay = $urandom_range(0, rmax); end
            end
        end

        chk("stores_completed", 32'(n_stores_done > 200), 32'd1);
        chk("loads_completed", 32'(n_loads_done > 20), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
